// File: rtl/rr_reg_arbiter.sv
// Round-robin ownership arbiter guarding one shared DW-bit register.
// One requester owns the register at a time; only its writes land in q.
module rr_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic [DW-1:0]   q,
  output logic            upd,
  output logic [IW-1:0]   q_src,
  output logic            conflict
);

  localparam int unsigned HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]   gnt_id_q, gnt_id_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [DW-1:0]   q_q;
  logic            upd_q;
  logic [IW-1:0]   q_src_q;
  logic            conflict_q;

  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            others_pending;
  logic            release_own;
  logic            wr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   wr_src;
  logic            conf;

  // First requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IW'((int'(ptr_q) + k) % int'(N));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign others_pending = |(req & ~gnt_q);
  assign release_own    = !req[gnt_id_q] || ((hold_q == HoldLast) && others_pending);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StOwn;
          gnt_d    = N'(1) << win;
          gnt_id_d = win;
          busy_d   = 1'b1;
          hold_d   = '0;
          ptr_d    = IW'((int'(win) + 1) % int'(N));
        end
      end
      StOwn: begin
        if (release_own) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (hold_q != HoldLast) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Writes are judged against the registered grant seen during the cycle.
  always_comb begin
    wr      = 1'b0;
    wr_data = '0;
    wr_src  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (we[i] && gnt_q[i]) begin
        wr      = 1'b1;
        wr_data = din[i*DW +: DW];
        wr_src  = IW'(i);
      end
    end
    conf = |(we & ~gnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      ptr_q      <= '0;
      hold_q     <= '0;
      q_q        <= '0;
      upd_q      <= 1'b0;
      q_src_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      upd_q      <= wr;
      conflict_q <= conf;
      if (wr) begin
        q_q     <= wr_data;
        q_src_q <= wr_src;
      end
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign q        = q_q;
  assign upd      = upd_q;
  assign q_src    = q_src_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: per-cycle comparison against a behavioural
// ownership model plus directed scenarios with literal expectations.
module tb_rr_reg_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 8;
  localparam int IW       = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*DW-1:0] din;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            busy;
  logic [DW-1:0]   q;
  logic            upd;
  logic [IW-1:0]   q_src;
  logic            conflict;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 when nobody owns), rotation pointer, hold count.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_hold  = 0;
  logic [7:0]  m_q     = '0;
  logic        m_upd   = 1'b0;
  logic        m_conf  = 1'b0;
  int          m_src   = 0;
  int          m_c;
  logic        m_pend;

  always #5 clk = ~clk;

  rr_reg_arbiter #(
    .N        (N),
    .DW       (DW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .din      (din),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .q        (q),
    .upd      (upd),
    .q_src    (q_src),
    .conflict (conflict)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_ptr = 0; m_hold = 0;
        m_q = '0; m_upd = 1'b0; m_conf = 1'b0; m_src = 0;
      end else begin
        m_upd  = 1'b0;
        m_conf = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (we[i]) begin
            if (i == m_owner) begin
              m_q = din[i*DW +: DW]; m_src = i; m_upd = 1'b1;
            end else begin
              m_conf = 1'b1;
            end
          end
        end
        if (m_owner < 0) begin
          for (int k = 0; k < N; k++) begin
            m_c = (m_ptr + k) % N;
            if (m_owner < 0 && req[m_c]) m_owner = m_c;
          end
          if (m_owner >= 0) begin
            m_hold = 0;
            m_ptr  = (m_owner + 1) % N;
          end
        end else begin
          m_pend = 1'b0;
          for (int j = 0; j < N; j++) if (j != m_owner && req[j]) m_pend = 1'b1;
          if (!req[m_owner] || (m_hold == MAX_HOLD - 1 && m_pend)) m_owner = -1;
          else if (m_hold < MAX_HOLD - 1) m_hold++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("cmp_busy", 32'(busy), 32'(m_owner >= 0));
      if (m_owner >= 0) check("cmp_gnt_id", 32'(gnt_id), 32'(m_owner));
      check("cmp_q", 32'(q), 32'(m_q));
      check("cmp_upd", 32'(upd), 32'(m_upd));
      check("cmp_q_src", 32'(q_src), 32'(m_src));
      check("cmp_conflict", 32'(conflict), 32'(m_conf));
    end
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; din = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_q_src", 32'(q_src), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);

    // Single requester, long hold without competition.
    req = 4'b0100;
    step();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_gnt_id", 32'(gnt_id), 32'd2);
    check("single_busy", 32'(busy), 32'd1);
    we = 4'b0100; din[2*DW +: DW] = 8'h3C;
    step();
    check("single_q", 32'(q), 32'h3C);
    check("single_upd", 32'(upd), 32'd1);
    check("single_q_src", 32'(q_src), 32'd2);
    check("single_conflict", 32'(conflict), 32'd0);
    we = '0;
    repeat (22) step();
    check("single_hold_long", 32'(gnt), 32'h4);
    req = '0;
    step();
    check("single_release_gnt", 32'(gnt), 32'd0);
    check("single_release_busy", 32'(busy), 32'd0);

    // Wrap: pointer sits at 3.
    req = 4'b1001;
    step();
    check("wrap_first", 32'(gnt), 32'h8);
    check("wrap_first_id", 32'(gnt_id), 32'd3);
    req = 4'b0001;
    step();
    check("wrap_idle", 32'(gnt), 32'd0);
    step();
    check("wrap_second", 32'(gnt), 32'h1);
    check("wrap_second_id", 32'(gnt_id), 32'd0);
    req = '0;
    step();
    req = 4'b0011;
    step();
    check("wrap_ptr_is_1", 32'(gnt), 32'h2);
    req = '0;
    step();

    // Asynchronous reset mid-grant.
    req = 4'b0001;
    step();
    check("arst_pre_gnt", 32'(gnt), 32'h1);
    we = 4'b0001; din[0 +: DW] = 8'hA5;
    step();
    check("arst_pre_q", 32'(q), 32'hA5);
    we = '0;
    #2 rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_q", 32'(q), 32'd0);
    check("arst_upd", 32'(upd), 32'd0);
    check("arst_gnt_id", 32'(gnt_id), 32'd0);
    req = '0;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    check("arst_after_gnt", 32'(gnt), 32'd0);
    check("arst_after_busy", 32'(busy), 32'd0);

    // Fairness: each owner holds two cycles, one idle cycle between owners.
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      step();
      check("rr_grant_c1", 32'(gnt), 32'd1 << (o % 4));
      step();
      check("rr_grant_c2", 32'(gnt), 32'd1 << (o % 4));
      req = 4'b1111 & ~(4'b0001 << (o % 4));
      step();
      check("rr_idle", 32'(gnt), 32'd0);
      check("rr_idle_busy", 32'(busy), 32'd0);
      req = (o == 4) ? 4'b0000 : 4'b1111;
    end

    // Forced release after MAX_HOLD cycles with a competitor waiting.
    req = 4'b0010;
    step();
    check("force_c1", 32'(gnt), 32'h2);
    step();
    check("force_c2", 32'(gnt), 32'h2);
    req = 4'b1010;
    for (int c = 3; c <= 8; c++) begin
      step();
      check("force_hold", 32'(gnt), 32'h2);
    end
    step();
    check("force_idle", 32'(gnt), 32'd0);
    step();
    check("force_next", 32'(gnt), 32'h8);
    check("force_next_id", 32'(gnt_id), 32'd3);
    req = '0;
    step();

    // Owner write alongside a non-owner write.
    req = 4'b0001;
    step();
    check("conf_gnt", 32'(gnt), 32'h1);
    we = 4'b0101; din[0 +: DW] = 8'h11; din[2*DW +: DW] = 8'hFF;
    step();
    check("conf_q", 32'(q), 32'h11);
    check("conf_q_src", 32'(q_src), 32'd0);
    check("conf_upd", 32'(upd), 32'd1);
    check("conf_flag", 32'(conflict), 32'd1);
    we = '0;
    step();
    check("conf_upd_clr", 32'(upd), 32'd0);
    check("conf_flag_clr", 32'(conflict), 32'd0);
    check("conf_q_keep", 32'(q), 32'h11);
    req = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
